divider_arbiter: RTL and testbench
==================================

// Module: divider_arbiter
// PURPOSE
//  Shares one multi-cycle `divider` instance between NUM_REQ requesters, e.g. periodic
//  test trigger, manta debug writes, and datapath users. Arbitrates round-robin, issues
//  operands and a one-cycle start pulse to the divider, and waits for its result. Returns
//  the result to the granted requester with a one-cycle valid pulse. Zero divisors are
//  handled locally, and a hung divider is bounded by a timeout.
// PARAMETERS
//  WIDTH    32  operand/result width in bits
//  NUM_REQ  4   number of requesters (2..8)
//  TIMEOUT  64  max cycles in WAIT before error response (>=2)
// PORTS
//  clk_in              in   1              system clock (100 MHz domain)
//  rst_in              in   1              async active-high reset
//  req_valid_in        in   NUM_REQ        per-requester request
//  req_dividend_in     in   NUM_REQ*WIDTH  requester i in bits [i*WIDTH +: WIDTH]
//  req_divisor_in      in   NUM_REQ*WIDTH  same packing
//  req_ready_out       out  NUM_REQ        one-hot acceptance strobe
//  resp_valid_out      out  NUM_REQ        one-hot one-cycle result strobe
//  resp_quotient_out   out  WIDTH          shared result bus, valid with resp_valid_out
//  resp_remainder_out  out  WIDTH          shared result bus
//  resp_error_out      out  1              zero divisor, divider error, or timeout
//  div_dividend_out    out  WIDTH          to divider dividend_in
//  div_divisor_out     out  WIDTH          to divider divisor_in
//  div_valid_out       out  1              to divider data_valid_in (start pulse)
//  div_quotient_in     in   WIDTH          from divider
//  div_remainder_in    in   WIDTH          from divider
//  div_valid_in        in   1              from divider data_valid_out
//  div_error_in        in   1              from divider error_out (sampled with div_valid_in)
//  busy_out            out  1              high in every state except IDLE
//  grant_id_out        out  clog2(NUM_REQ) index of current/last grant
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, timer=0, all outputs and operand/result regs 0.
//  FSM: IDLE -> ISSUE | RESPOND; ISSUE -> WAIT; WAIT -> RESPOND; RESPOND -> IDLE.
//  IDLE: grant g = first i with req_valid_in[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready_out[g]=1 combinationally in that cycle; operands latched at that edge.
//   - Edge also sets grant_id_out=g, rr_ptr=(g+1)%NUM_REQ.
//   - Next state RESPOND if latched divisor==0, else ISSUE. No request: stay, ready_out=0.
//  Request handshake: requester holds valid + operands stable until it sees ready.
//   - Deasserting valid before grant is legal (request withdrawn).
//  ISSUE: div_valid_out=1 for exactly this cycle; div_dividend/divisor_out are driven
//   from latched regs in all states. Next WAIT, timer=0.
//  WAIT: timer increments each cycle.
//   - div_valid_in=1: latch quotient/remainder, err=div_error_in, go RESPOND.
//   - timer==TIMEOUT-1 without div_valid_in: q=0, r=0, err=1, go RESPOND.
//   - Both in same cycle: divider result wins.
//  RESPOND: resp_valid_out[grant_id_out]=1 for one cycle, buses hold latched values.
//   - No backpressure. Next IDLE; a new grant is possible on the following cycle.
//  Zero divisor: q={WIDTH{1'b1}}, r=dividend, err=1; divider is never started.
//  Latency, accept edge = cycle 0: div_valid_out in cycle 1.
//   - Divider valid in cycle 1+L gives resp_valid in cycle 2+L.
//   - Zero divisor gives resp_valid in cycle 1.
//  Throughput: one op in flight; no request accepted from ISSUE through RESPOND.
//  div_valid_in outside WAIT is ignored, e.g. a stale result after reset or after timeout.
//  Outside RESPOND, resp_* buses keep their last values, but resp_valid_out=0.
//  Reset mid-op: in-flight op is dropped with no response; requester must re-request.
// TESTING
//  1 Single op: req0 100/7 -> ready0 @c0, div_valid_out @c1, resp_valid[0] q=14 r=2 err=0.
//  2 Contention: req0..3 held, 4 ops -> grants 0,1,2,3 in order; repeat, then rr_ptr=0.
//  3 Fairness: rr_ptr=2, req1+req3 -> grant 3, then grant 1.
//  4 Zero divisor: req2 55/0 -> resp_valid[2] next cycle, q=FFFFFFFF r=55 err=1, no start.
//  5 Timeout: divider model never answers -> resp err=1 q=0 r=0 after TIMEOUT cycles.
//    Late div_valid_in afterwards is ignored.
//  6 Reset during WAIT -> all outputs 0 same cycle, no resp pulse; next req served normally.

Source files
------------

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider among NUM_REQ requesters.
// Zero divisors are answered locally; a silent divider is bounded by a timeout.
//
// state   | meaning
// IDLE    | arbitrate; ready strobe to winner, operands latched on that edge
// ISSUE   | one-cycle start pulse to the divider
// WAIT    | waiting for divider result or timeout
// RESPOND | one-cycle result strobe to the granted requester
module divider_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0]     req_dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0]     req_divisor_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic [NUM_REQ-1:0]           resp_valid_out,
    output logic [WIDTH-1:0]             resp_quotient_out,
    output logic [WIDTH-1:0]             resp_remainder_out,
    output logic                         resp_error_out,
    output logic [WIDTH-1:0]             div_dividend_out,
    output logic [WIDTH-1:0]             div_divisor_out,
    output logic                         div_valid_out,
    input  logic [WIDTH-1:0]             div_quotient_in,
    input  logic [WIDTH-1:0]             div_remainder_in,
    input  logic                         div_valid_in,
    input  logic                         div_error_in,
    output logic                         busy_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_out
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t           state, state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   pick;
    logic             found;
    logic             accept;
    logic             timed_out;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] dividend_r, divisor_r, quotient_r, remainder_r;
    logic             error_r;
    logic [WIDTH-1:0] pick_dividend, pick_divisor;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        return IDW'((int'(base) + offset) % NUM_REQ);
    endfunction

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid_in[rr_index(rr_ptr, k)]) begin
                found = 1'b1;
                pick  = rr_index(rr_ptr, k);
            end
        end
    end

    assign pick_dividend = req_dividend_in[int'(pick)*WIDTH +: WIDTH];
    assign pick_divisor  = req_divisor_in[int'(pick)*WIDTH +: WIDTH];
    assign accept        = (state == IDLE) && found;
    assign timed_out     = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = (pick_divisor == '0) ? RESPOND : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (div_valid_in || timed_out) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            timer       <= '0;
            dividend_r  <= '0;
            divisor_r   <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            error_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend_r <= pick_dividend;
                        divisor_r  <= pick_divisor;
                        grant_id   <= pick;
                        rr_ptr     <= rr_index(pick, 1);
                        if (pick_divisor == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= pick_dividend;
                            error_r     <= 1'b1;
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A result arriving on the timeout cycle still wins.
                    if (div_valid_in) begin
                        quotient_r  <= div_quotient_in;
                        remainder_r <= div_remainder_in;
                        error_r     <= div_error_in;
                    end else if (timed_out) begin
                        quotient_r  <= '0;
                        remainder_r <= '0;
                        error_r     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_out      = accept ? (NUM_REQ'(1) << pick) : '0;
    assign resp_valid_out     = (state == RESPOND) ? (NUM_REQ'(1) << grant_id) : '0;
    assign resp_quotient_out  = quotient_r;
    assign resp_remainder_out = remainder_r;
    assign resp_error_out     = error_r;
    assign div_dividend_out   = dividend_r;
    assign div_divisor_out    = divisor_r;
    assign div_valid_out      = (state == ISSUE);
    assign busy_out           = (state != IDLE);
    assign grant_id_out       = grant_id;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus random traffic, checked by a
// round-robin/latency reference model feeding a response scoreboard.
`timescale 1ns/1ps
module tb_divider_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = $clog2(NUM_REQ);

    logic                       clk_in = 1'b0;
    logic                       rst_in = 1'b1;
    logic [NUM_REQ-1:0]         req_valid_in = '0;
    logic [NUM_REQ*WIDTH-1:0]   req_dividend_in = '0;
    logic [NUM_REQ*WIDTH-1:0]   req_divisor_in = '0;
    logic [NUM_REQ-1:0]         req_ready_out;
    logic [NUM_REQ-1:0]         resp_valid_out;
    logic [WIDTH-1:0]           resp_quotient_out;
    logic [WIDTH-1:0]           resp_remainder_out;
    logic                       resp_error_out;
    logic [WIDTH-1:0]           div_dividend_out;
    logic [WIDTH-1:0]           div_divisor_out;
    logic                       div_valid_out;
    logic [WIDTH-1:0]           div_quotient_in = '0;
    logic [WIDTH-1:0]           div_remainder_in = '0;
    logic                       div_valid_in = 1'b0;
    logic                       div_error_in = 1'b0;
    logic                       busy_out;
    logic [IDW-1:0]             grant_id_out;

    divider_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_dividend_in(req_dividend_in),
        .req_divisor_in(req_divisor_in), .req_ready_out(req_ready_out),
        .resp_valid_out(resp_valid_out), .resp_quotient_out(resp_quotient_out),
        .resp_remainder_out(resp_remainder_out), .resp_error_out(resp_error_out),
        .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
        .div_valid_out(div_valid_out), .div_quotient_in(div_quotient_in),
        .div_remainder_in(div_remainder_in), .div_valid_in(div_valid_in),
        .div_error_in(div_error_in), .busy_out(busy_out), .grant_id_out(grant_id_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bad(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        int               id;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             err;
        int               cyc;
    } resp_t;

    resp_t sb[$];

    logic [WIDTH-1:0]   dvd [NUM_REQ];
    logic [WIDTH-1:0]   dvs [NUM_REQ];
    bit                 stage_v [NUM_REQ];
    logic [WIDTH-1:0]   stage_a [NUM_REQ];
    logic [WIDTH-1:0]   stage_b [NUM_REQ];
    bit [NUM_REQ-1:0]   drop_mask = '0;

    int rr_m = 0;
    int free_cyc = 0;
    int busy_from = 0;
    bit rand_en = 1'b0;
    int fixed_lat = 0;
    bit force_hang = 1'b0;

    bit               start_pending = 1'b0;
    int               st_cyc = 0;
    int               st_lat = 1;
    bit               st_hang = 1'b0;
    bit               st_err = 1'b0;
    logic [WIDTH-1:0] st_a = '0;
    logic [WIDTH-1:0] st_b = '0;
    int               stale_cyc = -1;

    function automatic logic [WIDTH-1:0] rnd_divisor();
        int s;
        s = $urandom_range(9);
        if (s == 0) return '0;
        if (s < 4) return WIDTH'($urandom_range(15, 1));
        return WIDTH'($urandom);
    endfunction

    task automatic stage(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        stage_v[i] = 1'b1;
        stage_a[i] = a;
        stage_b[i] = b;
    endtask

    task automatic drive_ops(input int i);
        req_dividend_in[i*WIDTH +: WIDTH] = dvd[i];
        req_divisor_in[i*WIDTH +: WIDTH]  = dvs[i];
        req_valid_in[i] = 1'b1;
    endtask

    // One clock: update requests just after the edge, check and model before the next edge.
    task automatic tick();
        int g;
        int idx;
        logic [NUM_REQ-1:0] exp_rdy;
        resp_t e;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drop_mask[i]) req_valid_in[i] = 1'b0;
            if (stage_v[i] && !req_valid_in[i]) begin
                dvd[i] = stage_a[i];
                dvs[i] = stage_b[i];
                stage_v[i] = 1'b0;
                drive_ops(i);
            end else if (rand_en && !req_valid_in[i] && !drop_mask[i] && $urandom_range(99) < 25) begin
                dvd[i] = WIDTH'($urandom);
                dvs[i] = rnd_divisor();
                drive_ops(i);
            end else if (rand_en && req_valid_in[i] && $urandom_range(99) < 2) begin
                req_valid_in[i] = 1'b0;
            end
        end
        drop_mask = '0;

        @(negedge clk_in);
        g = -1;
        if (!rst_in && cyc >= free_cyc) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rr_m + k) % NUM_REQ;
                if (g < 0 && req_valid_in[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready_out), 64'(exp_rdy));
        chk("busy", 64'(busy_out), 64'(cyc >= busy_from && cyc < free_cyc));

        if (g >= 0) begin
            e.id = g;
            if (dvs[g] == '0) begin
                e.q = '1;
                e.r = dvd[g];
                e.err = 1'b1;
                e.cyc = cyc + 1;
            end else begin
                st_hang = force_hang || (rand_en && $urandom_range(19) == 0);
                st_lat  = (fixed_lat > 0) ? fixed_lat
                        : (($urandom_range(19) == 0) ? TIMEOUT : int'($urandom_range(8, 1)));
                st_err  = rand_en && ($urandom_range(7) == 0);
                st_a = dvd[g];
                st_b = dvs[g];
                st_cyc = cyc + 1;
                start_pending = 1'b1;
                if (st_hang) begin
                    e.q = '0;
                    e.r = '0;
                    e.err = 1'b1;
                    e.cyc = cyc + 2 + TIMEOUT;
                end else begin
                    e.q = dvd[g] / dvs[g];
                    e.r = dvd[g] % dvs[g];
                    e.err = st_err;
                    e.cyc = cyc + 2 + st_lat;
                end
            end
            sb.push_back(e);
            busy_from = cyc + 1;
            free_cyc = e.cyc + 1;
            rr_m = (g + 1) % NUM_REQ;
            drop_mask[g] = 1'b1;
        end
    endtask

    function automatic bit all_idle();
        bit staged;
        staged = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (stage_v[i]) staged = 1'b1;
        return !staged && req_valid_in == '0 && sb.size() == 0 && cyc >= free_cyc && !start_pending;
    endfunction

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < maxc && !all_idle());
        if (!all_idle()) bad("wait_idle cycle budget expired");
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " req_ready"}, 64'(req_ready_out), 64'd0);
        chk({tag, " resp_valid"}, 64'(resp_valid_out), 64'd0);
        chk({tag, " resp_quotient"}, 64'(resp_quotient_out), 64'd0);
        chk({tag, " resp_remainder"}, 64'(resp_remainder_out), 64'd0);
        chk({tag, " resp_error"}, 64'(resp_error_out), 64'd0);
        chk({tag, " div_dividend"}, 64'(div_dividend_out), 64'd0);
        chk({tag, " div_divisor"}, 64'(div_divisor_out), 64'd0);
        chk({tag, " div_valid"}, 64'(div_valid_out), 64'd0);
        chk({tag, " busy"}, 64'(busy_out), 64'd0);
        chk({tag, " grant_id"}, 64'(grant_id_out), 64'd0);
    endtask

    // Divider model: checks each start pulse and answers after the chosen latency.
    bit               run = 1'b0;
    int               fire_cyc = 0;
    logic [WIDTH-1:0] ra = '0;
    logic [WIDTH-1:0] rb = '0;
    bit               rerr = 1'b0;

    always @(negedge clk_in) begin
        if (rst_in) begin
            div_valid_in = 1'b0;
            div_error_in = 1'b0;
            run = 1'b0;
        end else begin
            div_valid_in = 1'b0;
            div_error_in = 1'b0;
            if (div_valid_out) begin
                if (!start_pending) begin
                    bad("unexpected divider start");
                end else begin
                    chk("start cycle", 64'(cyc), 64'(st_cyc));
                    chk("div_dividend", 64'(div_dividend_out), 64'(st_a));
                    chk("div_divisor", 64'(div_divisor_out), 64'(st_b));
                    start_pending = 1'b0;
                    if (!st_hang) begin
                        run = 1'b1;
                        fire_cyc = cyc + st_lat;
                        ra = div_dividend_out;
                        rb = div_divisor_out;
                        rerr = st_err;
                    end
                end
            end else if (start_pending && cyc > st_cyc) begin
                bad("missing divider start");
                start_pending = 1'b0;
            end
            if (run && cyc == fire_cyc) begin
                div_valid_in = 1'b1;
                div_quotient_in = (rb == '0) ? '1 : ra / rb;
                div_remainder_in = (rb == '0) ? ra : ra % rb;
                div_error_in = rerr;
                run = 1'b0;
            end
            if (cyc == stale_cyc) begin
                div_valid_in = 1'b1;
                div_quotient_in = 32'h0BAD_F00D;
                div_remainder_in = 32'h1234_5678;
                div_error_in = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a result strobe appears.
    always @(negedge clk_in) begin
        resp_t e;
        if (!rst_in) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                bad("response missing");
                void'(sb.pop_front());
            end
            if (resp_valid_out != '0) begin
                if (sb.size() == 0) begin
                    bad("unexpected response");
                end else begin
                    e = sb.pop_front();
                    chk("resp cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_valid", 64'(resp_valid_out), 64'(1) << e.id);
                    chk("grant_id", 64'(grant_id_out), 64'(e.id));
                    chk("resp_quotient", 64'(resp_quotient_out), 64'(e.q));
                    chk("resp_remainder", 64'(resp_remainder_out), 64'(e.r));
                    chk("resp_error", 64'(resp_error_out), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dvd[i] = '0;
            dvs[i] = '0;
            stage_v[i] = 1'b0;
            stage_a[i] = '0;
            stage_b[i] = '0;
        end
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset");
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Single op 100/7 with a 3-cycle divider.
        fixed_lat = 3;
        stage(0, 100, 7);
        wait_idle(100);

        // Move the pointer back to 0, then contend with all four twice.
        stage(3, 81, 9);
        wait_idle(100);
        fixed_lat = 2;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < NUM_REQ; i++) stage(i, WIDTH'($urandom), WIDTH'($urandom_range(100, 1)));
            wait_idle(200);
        end

        // Fairness: pointer at 2 with requesters 1 and 3 pending.
        stage(1, 50, 5);
        wait_idle(100);
        stage(1, 77, 4);
        stage(3, 1000, 33);
        wait_idle(200);

        // Zero divisor is answered locally.
        stage(2, 55, 0);
        wait_idle(50);

        // Divider never answers, then a stale result arrives while idle.
        force_hang = 1'b1;
        stage(0, 12345, 6);
        wait_idle(TIMEOUT + 20);
        force_hang = 1'b0;
        stale_cyc = cyc + 2;
        repeat (6) tick();
        stale_cyc = -1;

        // Reset while waiting on the divider.
        force_hang = 1'b1;
        stage(1, 1000, 3);
        repeat (12) tick();
        force_hang = 1'b0;
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        req_valid_in = '0;
        drop_mask = '0;
        #1 check_outputs_zero("mid-op reset");
        sb.delete();
        start_pending = 1'b0;
        rr_m = 0;
        free_cyc = 0;
        busy_from = 0;
        repeat (2) tick();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        fixed_lat = 4;
        stage(2, 999, 10);
        wait_idle(100);

        // Random traffic.
        fixed_lat = 0;
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        wait_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
